// File: rtl/ysyx_22041211_lsu_pkg.sv
// LSU shared definitions: load/store encodings,
// FSM states and the store strobe helper.
package ysyx_22041211_lsu_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } load_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  function automatic logic [3:0] store_strb(
    input logic [1:0] st,
    input logic [1:0] lane
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      (st == ST_SB): s = 4'b0001 << lane;
      (st == ST_SH): s = 4'b0011 << lane;
      (st == ST_SW): s = 4'b1111;
      default:       s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ysyx_22041211_load_fmt.sv
// Load data extraction: shift the read word down
// to the byte lane, then sign/zero extend.
module ysyx_22041211_load_fmt
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          lane,
  input  logic [2:0]          load_type,
  output logic [DATA_LEN-1:0] data
);

  logic [DATA_LEN-1:0] sh;

  assign sh = rdata >> {lane, 3'b000};

  // Pick the extension for the load width
  always_comb begin
    data = '0;
    unique case (1'b1)
      (load_type == LD_LB):
        data = {{(DATA_LEN-8){sh[7]}}, sh[7:0]};
      (load_type == LD_LBU):
        data = {{(DATA_LEN-8){1'b0}}, sh[7:0]};
      (load_type == LD_LH):
        data = {{(DATA_LEN-16){sh[15]}}, sh[15:0]};
      (load_type == LD_LHU):
        data = {{(DATA_LEN-16){1'b0}}, sh[15:0]};
      (load_type == LD_LW):
        data = sh;
      default:
        data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: accepts one instruction from EXU,
// runs at most one bus transaction, hands result to WB.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                mem_wen_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic [DATA_LEN-1:0] bus_addr_o,
  output logic                bus_wen_o,
  output logic [DATA_LEN-1:0] bus_wdata_o,
  output logic [3:0]          bus_wstrb_o,
  input  logic                bus_resp_valid_i,
  input  logic [DATA_LEN-1:0] bus_rdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                misalign_o
);

  state_e state;

  logic                wd_r;
  logic [1:0]          lane_r;
  logic [2:0]          ld_r;
  logic [1:0]          st_r;
  logic [DATA_LEN-1:0] alu_r;
  logic [DATA_LEN-1:0] sdata_r;

  logic                accept;
  logic                is_load;
  logic                is_store;
  logic                non_mem;
  logic                mis;
  logic [1:0]          lane;
  logic [DATA_LEN-1:0] fmt_data;
  logic                unused_bits;

  // Store intent is carried by store_type_i alone
  assign unused_bits = mem_wen_i ^ (^st_r)
                     ^ (^alu_r) ^ (^sdata_r);

  assign ex_ready_o = (state == S_IDLE)
                   || (state == S_OUT && wb_ready_i);
  assign accept = ex_valid_i && ex_ready_o;

  assign lane     = alu_result_i[1:0];
  assign is_load  = (load_type_i != LD_NONE);
  assign is_store = !is_load
                 && (store_type_i != ST_NONE);
  assign non_mem  = !is_load && !is_store;

  // Misalignment check; a load overrides the store
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (load_type_i == LD_LH),
      (load_type_i == LD_LHU):
        mis = lane[0];
      (load_type_i == LD_LW):
        mis = (lane != 2'b00);
      (is_store && store_type_i == ST_SH):
        mis = lane[0];
      (is_store && store_type_i == ST_SW):
        mis = (lane != 2'b00);
      default:
        mis = 1'b0;
    endcase
  end

  ysyx_22041211_load_fmt #(
    .DATA_LEN(DATA_LEN)
  ) u_fmt (
    .rdata     (bus_rdata_i),
    .lane      (lane_r),
    .load_type (ld_r),
    .data      (fmt_data)
  );

  // Transaction FSM with registered bus and WB outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wd_r            <= 1'b0;
      lane_r          <= 2'b00;
      ld_r            <= 3'd0;
      st_r            <= 2'd0;
      alu_r           <= '0;
      sdata_r         <= '0;
      bus_req_valid_o <= 1'b0;
      bus_addr_o      <= '0;
      bus_wen_o       <= 1'b0;
      bus_wdata_o     <= '0;
      bus_wstrb_o     <= 4'b0000;
      wb_valid_o      <= 1'b0;
      wd_o            <= 1'b0;
      wreg_o          <= 5'd0;
      wdata_o         <= '0;
      misalign_o      <= 1'b0;
    end else if (accept) begin
      wd_r    <= wd_i;
      lane_r  <= lane;
      ld_r    <= load_type_i;
      st_r    <= is_store ? store_type_i : 2'd0;
      alu_r   <= alu_result_i;
      sdata_r <= mem_wdata_i;
      wreg_o  <= wreg_i;
      misalign_o <= mis;
      if (non_mem || mis) begin
        state           <= S_OUT;
        wb_valid_o      <= 1'b1;
        bus_req_valid_o <= 1'b0;
        wd_o    <= non_mem ? wd_i : 1'b0;
        wdata_o <= non_mem ? alu_result_i : '0;
      end else begin
        state           <= S_REQ;
        wb_valid_o      <= 1'b0;
        bus_req_valid_o <= 1'b1;
        bus_addr_o <=
          {alu_result_i[DATA_LEN-1:2], 2'b00};
        bus_wen_o <= is_store;
        bus_wstrb_o <= is_store
          ? store_strb(store_type_i, lane)
          : 4'b0000;
        bus_wdata_o <= is_store
          ? (mem_wdata_i << {lane, 3'b000})
          : '0;
        wd_o    <= 1'b0;
        wdata_o <= '0;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (bus_req_ready_i) begin
            bus_req_valid_o <= 1'b0;
            state           <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus_resp_valid_i) begin
            state      <= S_OUT;
            wb_valid_o <= 1'b1;
            wd_o <= (ld_r != LD_NONE) ? wd_r : 1'b0;
            wdata_o <= (ld_r != LD_NONE)
              ? fmt_data : '0;
          end
        end
        S_OUT: begin
          if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for the LSU: ALU pass-through,
// loads, stores, misalignment and reset abort.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i;
  logic        mem_wen_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_wen_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_resp_valid_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .wd_i             (wd_i),
    .wreg_i           (wreg_i),
    .alu_result_i     (alu_result_i),
    .mem_wen_i        (mem_wen_i),
    .mem_wdata_i      (mem_wdata_i),
    .load_type_i      (load_type_i),
    .store_type_i     (store_type_i),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_addr_o       (bus_addr_o),
    .bus_wen_o        (bus_wen_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_wstrb_o      (bus_wstrb_o),
    .bus_resp_valid_i (bus_resp_valid_i),
    .bus_rdata_i      (bus_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wd_o             (wd_o),
    .wreg_o           (wreg_o),
    .wdata_o          (wdata_o),
    .misalign_o       (misalign_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [2:0]  ld,
    input logic [1:0]  st,
    input logic [31:0] addr,
    input logic [31:0] sdata
  );
    ex_valid_i   = 1'b1;
    wd_i         = 1'b1;
    wreg_i       = 5'd7;
    load_type_i  = ld;
    store_type_i = st;
    mem_wen_i    = (st != 2'd0);
    alu_result_i = addr;
    mem_wdata_i  = sdata;
    step();
    ex_valid_i   = 1'b0;
  endtask

  task automatic do_load(
    input string       tag,
    input logic [2:0]  ld,
    input logic [31:0] addr,
    input logic [31:0] rdata,
    input logic [31:0] exp
  );
    issue(ld, 2'd0, addr, 32'h0);
    chk({tag, "_req"}, 32'(bus_req_valid_o), 1);
    chk({tag, "_addr"}, bus_addr_o,
        {addr[31:2], 2'b00});
    chk({tag, "_wen"}, 32'(bus_wen_o), 0);
    bus_req_ready_i = 1'b1;
    step();
    bus_req_ready_i = 1'b0;
    chk({tag, "_reqdone"}, 32'(bus_req_valid_o), 0);
    chk({tag, "_wait"}, 32'(wb_valid_o), 0);
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = rdata;
    step();
    bus_resp_valid_i = 1'b0;
    chk({tag, "_wbv"}, 32'(wb_valid_o), 1);
    chk({tag, "_data"}, wdata_o, exp);
    chk({tag, "_wd"}, 32'(wd_o), 1);
    chk({tag, "_mis"}, 32'(misalign_o), 0);
    step();
    chk({tag, "_drain"}, 32'(wb_valid_o), 0);
  endtask

  initial begin
    rst              = 1'b1;
    ex_valid_i       = 1'b0;
    wd_i             = 1'b0;
    wreg_i           = 5'd0;
    alu_result_i     = 32'h0;
    mem_wen_i        = 1'b0;
    mem_wdata_i      = 32'h0;
    load_type_i      = 3'd0;
    store_type_i     = 2'd0;
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_rdata_i      = 32'h0;
    wb_ready_i       = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(ex_ready_o), 1);
    chk("rst_req", 32'(bus_req_valid_o), 0);
    chk("rst_wbv", 32'(wb_valid_o), 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_strb", 32'(bus_wstrb_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_mis", 32'(misalign_o), 0);

    // ALU pass-through, back-to-back
    ex_valid_i   = 1'b1;
    wd_i         = 1'b1;
    wreg_i       = 5'd5;
    alu_result_i = 32'h1234;
    step();
    chk("alu0_v", 32'(wb_valid_o), 1);
    chk("alu0_d", wdata_o, 32'h1234);
    chk("alu0_r", 32'(wreg_o), 5);
    chk("alu0_wd", 32'(wd_o), 1);
    chk("alu0_rdy", 32'(ex_ready_o), 1);
    wreg_i       = 5'd6;
    alu_result_i = 32'h5678;
    step();
    chk("alu1_v", 32'(wb_valid_o), 1);
    chk("alu1_d", wdata_o, 32'h5678);
    chk("alu1_r", 32'(wreg_o), 6);
    ex_valid_i = 1'b0;
    step();
    chk("alu_idle", 32'(wb_valid_o), 0);

    do_load("lb", 3'd1, 32'h8000_0003,
            32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'd2, 32'h8000_0003,
            32'h80FF_0000, 32'h0000_0080);
    do_load("lh", 3'd3, 32'h8000_0002,
            32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'd4, 32'h8000_0002,
            32'h8001_0000, 32'h0000_8001);
    do_load("lw", 3'd5, 32'h8000_0004,
            32'hDEAD_BEEF, 32'hDEAD_BEEF);
    // load wins over a simultaneous store
    issue(3'd2, 2'd3, 32'h8000_0001, 32'h55);
    chk("ldst_wen", 32'(bus_wen_o), 0);
    chk("ldst_strb", 32'(bus_wstrb_o), 0);
    bus_req_ready_i = 1'b1;
    step();
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = 32'h0000_A500;
    step();
    bus_resp_valid_i = 1'b0;
    chk("ldst_data", wdata_o, 32'h0000_00A5);
    step();

    // SH with the bus stalling for 3 cycles
    issue(3'd0, 2'd2, 32'h8000_0002, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(bus_req_valid_o), 1);
      chk("sh_addr", bus_addr_o, 32'h8000_0000);
      chk("sh_strb", 32'(bus_wstrb_o), 32'hC);
      chk("sh_wdat", bus_wdata_o, 32'hABCD_0000);
      chk("sh_wen", 32'(bus_wen_o), 1);
      step();
    end
    bus_req_ready_i = 1'b1;
    step();
    bus_req_ready_i = 1'b0;
    chk("sh_reqdone", 32'(bus_req_valid_o), 0);
    bus_resp_valid_i = 1'b1;
    step();
    bus_resp_valid_i = 1'b0;
    chk("sh_wbv", 32'(wb_valid_o), 1);
    chk("sh_wd", 32'(wd_o), 0);
    chk("sh_data", wdata_o, 0);
    step();

    // SB at lane 1
    issue(3'd0, 2'd1, 32'h8000_0001, 32'h0000_0012);
    chk("sb_strb", 32'(bus_wstrb_o), 32'h2);
    chk("sb_wdat", bus_wdata_o, 32'h0000_1200);
    bus_req_ready_i = 1'b1;
    step();
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b1;
    step();
    bus_resp_valid_i = 1'b0;
    step();

    // misaligned LW, WB stalled 2 cycles
    wb_ready_i = 1'b0;
    issue(3'd5, 2'd0, 32'h8000_0001, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("mis_req", 32'(bus_req_valid_o), 0);
      chk("mis_wbv", 32'(wb_valid_o), 1);
      chk("mis_flag", 32'(misalign_o), 1);
      chk("mis_wd", 32'(wd_o), 0);
      chk("mis_data", wdata_o, 0);
      chk("mis_rdy", 32'(ex_ready_o), 0);
      if (i < 2) step();
    end
    wb_ready_i = 1'b1;
    step();
    chk("mis_done", 32'(wb_valid_o), 0);
    // misaligned SH
    issue(3'd0, 2'd2, 32'h8000_0003, 32'h1);
    chk("missh_req", 32'(bus_req_valid_o), 0);
    chk("missh_flag", 32'(misalign_o), 1);
    step();

    // reset while waiting for the response
    issue(3'd5, 2'd0, 32'h8000_0008, 32'h0);
    bus_req_ready_i = 1'b1;
    step();
    bus_req_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_rdy", 32'(ex_ready_o), 1);
    chk("ab_wbv", 32'(wb_valid_o), 0);
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = 32'h1111_1111;
    step();
    bus_resp_valid_i = 1'b0;
    chk("ab_stale", 32'(wb_valid_o), 0);
    chk("ab_rdy2", 32'(ex_ready_o), 1);
    do_load("lw2", 3'd5, 32'h8000_000C,
            32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_lsu.md
YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_lsu

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 32, giving the data and address width.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  EXU presents an instruction.
- ex_ready_o  out  1  LSU accepts the instruction this cycle.
- wd_i  in  1  register write enable.
- wreg_i  in  5  destination register.
- alu_result_i  in  DATA_LEN  ALU result or memory address.
- mem_wen_i  in  1  store instruction.
- mem_wdata_i  in  DATA_LEN  store data, right-aligned.
- load_type_i  in  3  load encoding; 0 = not a load.
- store_type_i  in  2  store encoding; 0 = not a store.
- bus_req_valid_o  out  1  memory request valid.
- bus_req_ready_i  in  1  memory accepts the request.
- bus_addr_o  out  DATA_LEN  word-aligned address.
- bus_wen_o  out  1  write request.
- bus_wdata_o  out  DATA_LEN  lane-shifted store data.
- bus_wstrb_o  out  4  byte strobes.
- bus_resp_valid_i  in  1  response valid; always accepted.
- bus_rdata_i  in  DATA_LEN  read word.
- wb_valid_o  out  1  result valid toward WB.
- wb_ready_i  in  1  WB accepts the result.
- wd_o  out  1  register write enable.
- wreg_o  out  5  destination register.
- wdata_o  out  DATA_LEN  write-back data.
- misalign_o  out  1  flags a misaligned access; qualified by wb_valid_o.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, RESP, OUT.
REQ-004 An instruction SHALL be accepted when ex_valid_i && ex_ready_o; ex_ready_o = (state==IDLE) || (state==OUT && wb_ready_i).
REQ-005 On acceptance, wd/wreg/alu_result/wdata/load_type/store_type SHALL be registered.
REQ-006 On acceptance, the FSM SHALL go to OUT if the instruction is non-memory or misaligned, else to REQ.
REQ-007 Non-memory latency SHALL be one cycle: accept at cycle N, wb_valid_o high at N+1, wdata_o = alu_result.
REQ-008 In REQ, bus_req_valid_o=1; address, wen, wdata and wstrb SHALL stay stable until bus_req_ready_i; on handshake go to RESP.
REQ-009 In RESP, wait for bus_resp_valid_i; on response go to OUT and latch the formatted data; a response in IDLE, REQ or OUT SHALL be ignored.
REQ-010 In OUT, wb_valid_o=1 and all wb outputs SHALL stay stable until wb_ready_i.
REQ-011 On the OUT handshake, go to IDLE, or take the new accept directly (back-to-back per REQ-004).
REQ-012 bus_addr_o SHALL be {addr[31:2],2'b00}, with byte lane = addr[1:0].
REQ-013 Store strobes SHALL be: SB 4'b0001<<lane, SH 4'b0011<<lane, SW 4'b1111; bus_wdata_o = data<<(8*lane).
REQ-014 Load data SHALL be formatted from rdata>>(8*lane):
- LB sign-extends bit 7; LBU zero-extends.
- LH sign-extends bit 15; LHU zero-extends.
- LW is passed unchanged.
REQ-015 For stores, wd_o SHALL be 0 and wdata_o SHALL be 0.
REQ-016 An access SHALL be misaligned when it is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-017 A misaligned access SHALL issue no bus request, complete in OUT with misalign_o=1, wd_o=0 and wdata_o=0.
REQ-018 If load_type and store_type are both non-zero, the instruction SHALL be treated as a load and the store SHALL be ignored.

Reset
REQ-019 While rst is high at a clock edge, the state SHALL go to IDLE.
REQ-020 After that edge, ex_ready_o=1 and the other outputs SHALL be 0: bus_req_valid_o, bus_wen_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, wb_valid_o, wd_o, wreg_o, wdata_o, misalign_o.
REQ-021 Reset asserted during REQ or RESP SHALL abandon the transaction, and any later response SHALL be ignored per REQ-009.

Structure
REQ-022 The shared define header SHALL hold:
- the load encodings: NONE 0, LB 1, LBU 2, LH 3, LHU 4, LW 5;
- the store encodings: NONE 0, SB 1, SH 2, SW 3;
- the FSM state encodings.
REQ-023 Load extraction and extension SHALL live in one combinational sub-module, ysyx_22041211_load_fmt (inputs rdata, lane, load_type; output formatted data).

Verification
REQ-024 Non-memory: ALU op with wd=1, wreg=5, result 0x1234 and wb_ready=1 -> wb_valid one cycle later with wdata 0x1234; back-to-back ops give one result per cycle.
REQ-025 LB at 0x80000003, rdata 0x80FF_0000 -> bus_addr 0x80000000, wdata 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-026 LH at 0x80000002, rdata 0x8001_0000 -> wdata 0xFFFF8001; the same access as LHU -> 0x00008001.
REQ-027 SH at 0x80000002, data 0xABCD, with req_ready held low 3 cycles -> stable request, wstrb 4'b1100, bus_wdata 0xABCD0000, wd_o 0.
REQ-028 LW at 0x80000001 -> no bus request, misalign_o=1 next cycle; wb_ready low 2 cycles -> outputs held.
REQ-029 Reset asserted in RESP, then a stale resp_valid -> IDLE, no wb_valid; the next LW completes normally.
